// File: rtl/mem_arbiter.sv
// Round-robin fetch/load-store arbiter for one synchronous word memory; grant and strobe in the request cycle, valid one cycle later.
// Requests are held until granted, one access per two cycles; MEM_ARB_ALIGN_CHECK_EN enables misalignment faults.
module mem_arbiter #(
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [31:0]       ls_addr,
  input  logic [31:0]       ls_wdata,
  input  logic [2:0]        ls_funct3,
  output logic              ls_gnt,
  output logic              ls_valid,
  output logic              ls_err,
  output logic [31:0]       ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, IF_WAIT, LS_WAIT} state_t;

  state_t      state;
  logic        last_ls;
  logic [2:0]  lat_f3;
  logic [1:0]  lat_off;
  logic        lat_we;
  logic        lat_err;
  logic [31:0] if_hold;
  logic [31:0] ls_hold;
  logic        idle;
  logic        f3_rsvd;
  logic        misalign;
  logic        ls_bad;
  logic        ls_go;
  logic [31:0] ls_fmt;
  logic        unused;

  function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = w >> {off, 3'b000};
    b  = sh[7:0];
    h  = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_fmt = {{24{b[7]}}, b};
      3'b100:  load_fmt = {24'd0, b};
      3'b001:  load_fmt = {{16{h[15]}}, h};
      3'b101:  load_fmt = {16'd0, h};
      3'b010:  load_fmt = w;
      default: load_fmt = 32'd0;
    endcase
  endfunction

  // grants are combinational so the memory sees the strobe in the request cycle
  assign idle   = (state == IDLE) && !rst;
  assign ls_gnt = idle && ls_req && (!if_req || !last_ls);
  assign if_gnt = idle && if_req && (!ls_req || last_ls);

  assign f3_rsvd = (ls_funct3 == 3'b011) || (ls_funct3[2:1] == 2'b11);
`ifdef MEM_ARB_ALIGN_CHECK_EN
  assign misalign = ((ls_funct3[1:0] == 2'b01) && ls_addr[0]) ||
                    ((ls_funct3[1:0] == 2'b10) && (ls_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif
  assign ls_bad = f3_rsvd || misalign;
  assign ls_go  = ls_gnt && !ls_bad;

  assign mem_en   = if_gnt || ls_go;
  assign mem_we   = ls_go && ls_we;
  assign mem_addr = if_gnt ? if_addr[MEM_AW+1:2] :
                    ls_go  ? ls_addr[MEM_AW+1:2] : '0;

  always_comb begin
    mem_be    = 4'b0000;
    mem_wdata = 32'd0;
    if (mem_we) begin
      case (ls_funct3[1:0])
        2'b00: begin
          mem_be    = 4'b0001 << ls_addr[1:0];
          mem_wdata = {4{ls_wdata[7:0]}};
        end
        2'b01: begin
          mem_be    = ls_addr[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {2{ls_wdata[15:0]}};
        end
        default: begin
          mem_be    = 4'b1111;
          mem_wdata = ls_wdata;
        end
      endcase
    end
  end

  assign ls_fmt   = (lat_err || lat_we) ? 32'd0 : load_fmt(lat_f3, lat_off, mem_rdata);
  assign ls_valid = (state == LS_WAIT);
  assign if_valid = (state == IF_WAIT);
  assign ls_err   = ls_valid && lat_err;
  assign ls_rdata = ls_valid ? ls_fmt : ls_hold;
  assign if_rdata = if_valid ? mem_rdata : if_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last_ls <= 1'b0;
      lat_f3  <= 3'b000;
      lat_off <= 2'b00;
      lat_we  <= 1'b0;
      lat_err <= 1'b0;
      if_hold <= 32'd0;
      ls_hold <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (ls_gnt) begin
            state   <= LS_WAIT;
            last_ls <= 1'b1;
            lat_f3  <= ls_funct3;
            lat_off <= ls_addr[1:0];
            lat_we  <= ls_we;
            lat_err <= ls_bad;
          end else if (if_gnt) begin
            state   <= IF_WAIT;
            last_ls <= 1'b0;
          end
        end
        IF_WAIT: begin
          if_hold <= mem_rdata;
          state   <= IDLE;
        end
        LS_WAIT: begin
          ls_hold <= ls_fmt;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // address bits outside the word index are intentionally ignored
  assign unused = ^{if_addr[31:MEM_AW+2], if_addr[1:0], ls_addr[31:MEM_AW+2]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: synchronous word memory model, vector table of loads/stores, collision and reset sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_valid;
  logic [31:0] if_rdata;
  logic        ls_req, ls_we;
  logic [31:0] ls_addr, ls_wdata;
  logic [2:0]  ls_funct3;
  logic        ls_gnt, ls_valid, ls_err;
  logic [31:0] ls_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        preload;
  logic [31:0] mem [256];
  logic [32:0] ls_q [$];
  logic [31:0] if_q [$];
  int          n_chk = 0;
  int          n_fail = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        en;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  vec_t       vt [19];
  logic [3:0] pat [6];

  mem_arbiter #(.MEM_AW(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_funct3(ls_funct3),
    .ls_gnt(ls_gnt), .ls_valid(ls_valid), .ls_err(ls_err), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      mem[8'h40] <= 32'hFFFFFFFF;
      mem[8'h41] <= 32'h80FF7F01;
      mem_rdata  <= 32'd0;
    end else if (mem_en) begin
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic en, input logic [3:0] be,
                              input logic [31:0] mwd, input logic [31:0] rd, input logic err);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wd = wd; v.en = en;
    v.be = be; v.mwd = mwd; v.rd = rd; v.err = err;
    return v;
  endfunction

  task automatic ls_op(input vec_t v);
    int          cyc;
    logic [32:0] e;
    ls_req = 1'b1; ls_we = v.we; ls_funct3 = v.f3; ls_addr = v.addr; ls_wdata = v.wd;
    #1;
    cyc = 0;
    while (!ls_gnt && cyc < 20) begin
      @(negedge clk); #1; cyc++;
    end
    if (!ls_gnt) begin
      chk("ls_gnt timeout", 32'd0, 32'd1);
      ls_req = 1'b0;
      return;
    end
    chk("mem_en", {31'd0, mem_en}, {31'd0, v.en});
    chk("mem_we", {31'd0, mem_we}, {31'd0, v.en & v.we});
    chk("mem_be", {28'd0, mem_be}, {28'd0, v.be});
    if (v.en && v.we) chk("mem_wdata", mem_wdata, v.mwd);
    if (v.en) chk("mem_addr", {24'd0, mem_addr}, {24'd0, v.addr[9:2]});
    ls_q.push_back({v.err, v.rd});
    @(negedge clk); ls_req = 1'b0; #1;
    chk("ls_valid", {31'd0, ls_valid}, 32'd1);
    chk("ls_gnt in wait", {31'd0, ls_gnt}, 32'd0);
    e = ls_q.pop_front();
    chk("ls_rdata", ls_rdata, e[31:0]);
    chk("ls_err", {31'd0, ls_err}, {31'd0, e[32]});
    @(negedge clk); #1;
    chk("ls_valid width", {31'd0, ls_valid}, 32'd0);
    chk("ls_rdata hold", ls_rdata, e[31:0]);
  endtask

  task automatic if_op(input logic [31:0] addr, input logic [31:0] exp);
    int cyc;
    if_req = 1'b1; if_addr = addr;
    #1;
    cyc = 0;
    while (!if_gnt && cyc < 20) begin
      @(negedge clk); #1; cyc++;
    end
    if (!if_gnt) begin
      chk("if_gnt timeout", 32'd0, 32'd1);
      if_req = 1'b0;
      return;
    end
    chk("if mem_en", {31'd0, mem_en}, 32'd1);
    chk("if mem_we", {31'd0, mem_we}, 32'd0);
    chk("if mem_be", {28'd0, mem_be}, 32'd0);
    chk("if mem_addr", {24'd0, mem_addr}, {24'd0, addr[9:2]});
    @(negedge clk); if_req = 1'b0; #1;
    chk("if_valid", {31'd0, if_valid}, 32'd1);
    chk("if_rdata", if_rdata, exp);
    @(negedge clk); #1;
    chk("if_valid width", {31'd0, if_valid}, 32'd0);
    chk("if_rdata hold", if_rdata, exp);
  endtask

  initial begin
    logic [32:0] le;
    logic [31:0] ie;

    // we   f3      addr          wdata          en    be       mem_wdata      rdata          err
    vt[0]  = mk(0, 3'b000, 32'h100, 32'h0, 1, 4'b0000, 32'h0, 32'hFFFFFFFF, 0);
    vt[1]  = mk(0, 3'b100, 32'h100, 32'h0, 1, 4'b0000, 32'h0, 32'h000000FF, 0);
    vt[2]  = mk(0, 3'b001, 32'h100, 32'h0, 1, 4'b0000, 32'h0, 32'hFFFFFFFF, 0);
    vt[3]  = mk(0, 3'b101, 32'h100, 32'h0, 1, 4'b0000, 32'h0, 32'h0000FFFF, 0);
    vt[4]  = mk(0, 3'b010, 32'h100, 32'h0, 1, 4'b0000, 32'h0, 32'hFFFFFFFF, 0);
    vt[5]  = mk(0, 3'b000, 32'h107, 32'h0, 1, 4'b0000, 32'h0, 32'hFFFFFF80, 0);
    vt[6]  = mk(0, 3'b100, 32'h106, 32'h0, 1, 4'b0000, 32'h0, 32'h000000FF, 0);
    vt[7]  = mk(0, 3'b000, 32'h105, 32'h0, 1, 4'b0000, 32'h0, 32'h0000007F, 0);
    vt[8]  = mk(0, 3'b001, 32'h106, 32'h0, 1, 4'b0000, 32'h0, 32'hFFFF80FF, 0);
    vt[9]  = mk(0, 3'b101, 32'h104, 32'h0, 1, 4'b0000, 32'h0, 32'h00007F01, 0);
`ifdef MEM_ARB_ALIGN_CHECK_EN
    vt[10] = mk(0, 3'b010, 32'h101, 32'h0, 0, 4'b0000, 32'h0, 32'h00000000, 1);
`else
    vt[10] = mk(0, 3'b010, 32'h101, 32'h0, 1, 4'b0000, 32'h0, 32'hFFFFFFFF, 0);
`endif
    vt[11] = mk(0, 3'b011, 32'h100, 32'h0, 0, 4'b0000, 32'h0, 32'h00000000, 1);
    vt[12] = mk(1, 3'b000, 32'h102, 32'h000000AB, 1, 4'b0100, 32'hABABABAB, 32'h0, 0);
    vt[13] = mk(0, 3'b010, 32'h100, 32'h0, 1, 4'b0000, 32'h0, 32'hFFABFFFF, 0);
    vt[14] = mk(1, 3'b001, 32'h106, 32'h00001234, 1, 4'b1100, 32'h12341234, 32'h0, 0);
    vt[15] = mk(0, 3'b010, 32'h104, 32'h0, 1, 4'b0000, 32'h0, 32'h12347F01, 0);
    vt[16] = mk(1, 3'b010, 32'h108, 32'hDEADBEEF, 1, 4'b1111, 32'hDEADBEEF, 32'h0, 0);
    vt[17] = mk(1, 3'b111, 32'h108, 32'h11111111, 0, 4'b0000, 32'h0, 32'h0, 1);
`ifdef MEM_ARB_ALIGN_CHECK_EN
    vt[18] = mk(0, 3'b001, 32'h103, 32'h0, 0, 4'b0000, 32'h0, 32'h00000000, 1);
`else
    vt[18] = mk(0, 3'b001, 32'h103, 32'h0, 1, 4'b0000, 32'h0, 32'hFFFFFFAB, 0);
`endif

    // {ls_gnt, ls_valid, if_gnt, if_valid} per cycle with both requests held
    pat[0] = 4'b1000; pat[1] = 4'b0100; pat[2] = 4'b0010;
    pat[3] = 4'b0001; pat[4] = 4'b1000; pat[5] = 4'b0100;

    rst = 1'b1; preload = 1'b1;
    if_req = 1'b1; if_addr = 32'h104;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100; ls_wdata = 32'h0; ls_funct3 = 3'b010;
    repeat (3) @(posedge clk);
    @(negedge clk); preload = 1'b0; #1;
    chk("rst if_gnt", {31'd0, if_gnt}, 32'd0);
    chk("rst ls_gnt", {31'd0, ls_gnt}, 32'd0);
    chk("rst valids", {30'd0, if_valid, ls_valid}, 32'd0);
    chk("rst ls_err", {31'd0, ls_err}, 32'd0);
    chk("rst mem_en/we", {30'd0, mem_en, mem_we}, 32'd0);
    chk("rst mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst rdata", if_rdata | ls_rdata, 32'd0);
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    if_req = 1'b1; ls_req = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("collision grant pattern", {28'd0, ls_gnt, ls_valid, if_gnt, if_valid}, {28'd0, pat[c]});
      if (ls_gnt) ls_q.push_back({1'b0, 32'hFFFFFFFF});
      if (if_gnt) if_q.push_back(32'h80FF7F01);
      if (ls_valid) begin
        if (ls_q.size() == 0) chk("unexpected ls_valid", 32'd1, 32'd0);
        else begin le = ls_q.pop_front(); chk("collision ls_rdata", ls_rdata, le[31:0]); end
      end
      if (if_valid) begin
        if (if_q.size() == 0) chk("unexpected if_valid", 32'd1, 32'd0);
        else begin ie = if_q.pop_front(); chk("collision if_rdata", if_rdata, ie); end
      end
      if (c == 5) begin if_req = 1'b0; ls_req = 1'b0; end
      @(negedge clk);
    end
    chk("collision queues drained", ls_q.size() + if_q.size(), 32'd0);

    for (int i = 0; i < 19; i++) ls_op(vt[i]);
    if_op(32'h10B, 32'hDEADBEEF);
    ls_op(mk(0, 3'b010, 32'h108, 32'h0, 1, 4'b0000, 32'h0, 32'hDEADBEEF, 0));

    // reset while a load is in flight drops it without a valid pulse
    ls_req = 1'b1; ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h100;
    #1;
    chk("pre-reset ls_gnt", {31'd0, ls_gnt}, 32'd1);
    @(negedge clk);
    rst = 1'b1; #1;
    chk("mid rst ls_valid", {31'd0, ls_valid}, 32'd0);
    chk("mid rst ls_gnt", {31'd0, ls_gnt}, 32'd0);
    chk("mid rst mem_en", {31'd0, mem_en}, 32'd0);
    chk("mid rst rdata", if_rdata | ls_rdata, 32'd0);
    ls_req = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    chk("post rst ls_valid", {31'd0, ls_valid}, 32'd0);
    @(negedge clk);
    ls_op(mk(0, 3'b010, 32'h108, 32'h0, 1, 4'b0000, 32'h0, 32'hDEADBEEF, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
